// File: rtl/digest_pkg.sv
// Shared definitions for the digest serializer: SHA type codes, the tuser
// field offset, per-type digest byte counts, the FSM state type and the
// last-word byte-enable helper.
package digest_pkg;

    localparam logic [1:0] SHA224 = 2'b00;
    localparam logic [1:0] SHA256 = 2'b01;
    localparam logic [1:0] SHA384 = 2'b10;
    localparam logic [1:0] SHA512 = 2'b11;

    localparam int unsigned SHA_TYPE_OFFSET = 32;

    localparam int unsigned SHA224_BYTES = 28;
    localparam int unsigned SHA256_BYTES = 32;
    localparam int unsigned SHA384_BYTES = 48;
    localparam int unsigned SHA512_BYTES = 64;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned CNT_W  = 5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    // Byte enables of the final word given the digest length modulo 4.
    function automatic logic [3:0] last_word_keep(input logic [1:0] rem);
        case (rem)
            2'd1:    return 4'b0001;
            2'd2:    return 4'b0011;
            2'd3:    return 4'b0111;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/keep_to_len.sv
// Priority encoder: byte length = index of highest set keep bit plus one.
// Ports: keep_i  byte-lane valid mask
//        len_c_o combinational byte length (0 when keep_i is all zero)
module keep_to_len #(
    parameter int unsigned KEEP_W = 64,
    parameter int unsigned LEN_W  = 7
) (
    input  logic [KEEP_W-1:0] keep_i,
    output logic [LEN_W-1:0]  len_c_o
);

    // Later iterations overwrite earlier ones, so the highest set bit wins.
    always_comb begin
        len_c_o = '0;
        for (int i = 0; i < KEEP_W; i++) begin
            if (keep_i[i]) begin
                len_c_o = LEN_W'(i + 1);
            end
        end
    end

endmodule

// File: rtl/digest_serializer.sv
// Splits one wide digest beat into a stream of 32-bit AXIS words.
// Ports: axis_aclk/axis_resetn   clock, async active-low reset
//        s_axis_*                 one digest per beat (tlast ignored)
//        m_axis_*                 32-bit words, tlast on the final word,
//                                 tuser repeats the captured sideband
module digest_serializer
    import digest_pkg::*;
#(
    parameter int unsigned C_S_AXIS_DATA_WIDTH  = 512,
    parameter int unsigned C_M_AXIS_DATA_WIDTH  = 32,
    parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
    parameter int unsigned C_M_AXIS_TUSER_WIDTH = 128
) (
    input  logic                               axis_aclk,
    input  logic                               axis_resetn,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]     s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]   s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]    s_axis_tuser,
    input  logic                               s_axis_tvalid,
    input  logic                               s_axis_tlast,
    output logic                               s_axis_tready,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]     m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]   m_axis_tkeep,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]    m_axis_tuser,
    output logic                               m_axis_tvalid,
    output logic                               m_axis_tlast,
    input  logic                               m_axis_tready
);

    localparam int unsigned KEEP_W  = C_S_AXIS_DATA_WIDTH / 8;
    localparam int unsigned LEN_W   = $clog2(KEEP_W + 1);
    localparam int unsigned MKEEP_W = C_M_AXIS_DATA_WIDTH / 8;

    logic [1:0] rst_sync_q;
    logic       rst_n;

    state_e                             state_q, state_d;
    logic                               s_tready_q, s_tready_d;
    logic [C_S_AXIS_DATA_WIDTH-1:0]     data_q, data_d;
    logic [C_M_AXIS_TUSER_WIDTH-1:0]    tuser_q, tuser_d;
    logic [LEN_W-1:0]                   len_q, len_d;
    logic [CNT_W-1:0]                   cnt_q, cnt_d;
    logic [C_M_AXIS_DATA_WIDTH-1:0]     m_tdata_q, m_tdata_d;
    logic [MKEEP_W-1:0]                 m_tkeep_q, m_tkeep_d;
    logic                               m_tlast_q, m_tlast_d;
    logic                               m_tvalid_q, m_tvalid_d;

    logic [LEN_W-1:0]                   beat_len;
    logic                               load_word;
    logic [C_S_AXIS_DATA_WIDTH-1:0]     sel_data;
    logic [LEN_W-1:0]                   sel_len;
    logic [CNT_W-1:0]                   sel_idx;
    logic [CNT_W-1:0]                   sel_last_idx;

    // Every beat is a whole digest, so the slave tlast carries no information.
    logic unused_tlast;
    assign unused_tlast = s_axis_tlast;

    // Reset asserts immediately, releases two clock edges later.
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end
    assign rst_n = rst_sync_q[1];

    keep_to_len #(
        .KEEP_W (KEEP_W),
        .LEN_W  (LEN_W)
    ) u_keep_to_len (
        .keep_i  (s_axis_tkeep),
        .len_c_o (beat_len)
    );

    // State and output registers.
    always_ff @(posedge axis_aclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            s_tready_q <= 1'b1;
            data_q     <= '0;
            tuser_q    <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            m_tdata_q  <= '0;
            m_tkeep_q  <= '0;
            m_tlast_q  <= 1'b0;
            m_tvalid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            s_tready_q <= s_tready_d;
            data_q     <= data_d;
            tuser_q    <= tuser_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            m_tdata_q  <= m_tdata_d;
            m_tkeep_q  <= m_tkeep_d;
            m_tlast_q  <= m_tlast_d;
            m_tvalid_q <= m_tvalid_d;
        end
    end

    // Next-state logic; the first word is loaded straight from the slave
    // beat so it is presented the cycle after the handshake.
    always_comb begin
        state_d      = state_q;
        s_tready_d   = s_tready_q;
        data_d       = data_q;
        tuser_d      = tuser_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
        m_tdata_d    = m_tdata_q;
        m_tkeep_d    = m_tkeep_q;
        m_tlast_d    = m_tlast_q;
        m_tvalid_d   = m_tvalid_q;
        load_word    = 1'b0;
        sel_data     = data_q;
        sel_len      = len_q;
        sel_idx      = cnt_q;
        sel_last_idx = '0;

        case (state_q)
            ST_IDLE: begin
                // An empty beat is consumed without producing any word.
                if (s_axis_tvalid && s_tready_q && (beat_len != '0)) begin
                    state_d    = ST_SEND;
                    s_tready_d = 1'b0;
                    data_d     = s_axis_tdata;
                    tuser_d    = C_M_AXIS_TUSER_WIDTH'(s_axis_tuser);
                    len_d      = beat_len;
                    cnt_d      = '0;
                    m_tvalid_d = 1'b1;
                    load_word  = 1'b1;
                    sel_data   = s_axis_tdata;
                    sel_len    = beat_len;
                    sel_idx    = '0;
                end
            end
            ST_SEND: begin
                if (m_tvalid_q && m_axis_tready) begin
                    if (m_tlast_q) begin
                        state_d    = ST_IDLE;
                        s_tready_d = 1'b1;
                        m_tvalid_d = 1'b0;
                        m_tlast_d  = 1'b0;
                        cnt_d      = '0;
                    end else begin
                        cnt_d     = cnt_q + CNT_W'(1);
                        load_word = 1'b1;
                        sel_idx   = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: ;
        endcase

        // Index of the final word: ceil(len/4) - 1.
        sel_last_idx = CNT_W'((32'(sel_len) + 32'd3) >> 2) - CNT_W'(1);

        if (load_word) begin
            m_tdata_d = C_M_AXIS_DATA_WIDTH'(sel_data >> {sel_idx, 5'd0});
            m_tlast_d = (sel_idx == sel_last_idx);
            m_tkeep_d = m_tlast_d ? MKEEP_W'(last_word_keep(sel_len[1:0])) : '1;
        end
    end

    assign s_axis_tready = s_tready_q;
    assign m_axis_tdata  = m_tdata_q;
    assign m_axis_tkeep  = m_tkeep_q;
    assign m_axis_tuser  = tuser_q;
    assign m_axis_tvalid = m_tvalid_q;
    assign m_axis_tlast  = m_tlast_q;

endmodule

// File: tb/tb_digest_serializer.sv
// Scoreboard bench for digest_serializer: drivers push expected words from a
// byte-level model, a negedge monitor pops and compares every output word.
module tb_digest_serializer;
    import digest_pkg::*;

    localparam int unsigned DW = 512;
    localparam int unsigned KW = 64;
    localparam int unsigned UW = 128;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] s_tdata;
    logic [KW-1:0] s_tkeep;
    logic [UW-1:0] s_tuser;
    logic          s_tvalid, s_tlast, s_tready;
    logic [31:0]   m_tdata;
    logic [3:0]    m_tkeep;
    logic [UW-1:0] m_tuser;
    logic          m_tvalid, m_tlast, m_tready;

    always #5 clk = ~clk;

    digest_serializer dut (
        .axis_aclk     (clk),
        .axis_resetn   (rst_n),
        .s_axis_tdata  (s_tdata),
        .s_axis_tkeep  (s_tkeep),
        .s_axis_tuser  (s_tuser),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tlast  (s_tlast),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tkeep  (m_tkeep),
        .m_axis_tuser  (m_tuser),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tlast  (m_tlast),
        .m_axis_tready (m_tready)
    );

    typedef struct packed {
        logic [31:0]   data;
        logic [3:0]    keep;
        logic          last;
        logic [UW-1:0] user;
        logic          first;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   hs_cyc = 0;
    int   tl_cyc = -100;
    int   words_seen = 0;
    int   rdy_mode = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [UW-1:0] act, input logic [UW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endfunction

    function automatic logic [KW-1:0] ones(input int n);
        logic [KW-1:0] k;
        k = '0;
        for (int i = 0; i < n; i++) k[i] = 1'b1;
        return k;
    endfunction

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[32*i +: 32] = $urandom;
        return d;
    endfunction

    function automatic logic [UW-1:0] rand_user(input logic [1:0] sha);
        logic [UW-1:0] u;
        u = {$urandom, $urandom, $urandom, $urandom};
        u[SHA_TYPE_OFFSET +: 2] = sha;
        return u;
    endfunction

    // Reference model: digest is a byte string of length L; word w holds
    // bytes 4w..4w+3, and a byte lane is valid when its byte index is < L.
    task automatic push_expected(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic [UW-1:0] u);
        int   len;
        int   nw;
        exp_t e;
        len = 0;
        for (int i = 0; i < KW; i++) if (k[i]) len = i + 1;
        nw = (len + 3) / 4;
        for (int w = 0; w < nw; w++) begin
            e.data = d[32*w +: 32];
            for (int j = 0; j < 4; j++) e.keep[j] = ((4 * w + j) < len);
            e.last  = (w == nw - 1);
            e.user  = u;
            e.first = (w == 0);
            q.push_back(e);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the handshake edge.
    task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic [UW-1:0] u);
        int t;
        t = 0;
        s_tdata  = d;
        s_tkeep  = k;
        s_tuser  = u;
        s_tlast  = 1'b1;
        s_tvalid = 1'b1;
        forever begin
            @(negedge clk);
            if (s_tready) break;
            t++;
            if (t > 200) break;
        end
        if (t > 200) begin
            chk("s_tready_timeout", 128'(0), 128'(1));
        end else begin
            hs_cyc = cyc;
            push_expected(d, k, u);
        end
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (q.size() != 0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 3000) chk("drain_timeout", 128'(q.size()), 128'(0));
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Downstream ready: 0 = always, 1 = 1,0,0,1 repeating, 2 = random.
    initial begin
        int ph;
        ph = 0;
        m_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1:       m_tready = ((ph % 4) == 0) || ((ph % 4) == 3);
                2:       m_tready = ($urandom_range(0, 2) != 0);
                default: m_tready = 1'b1;
            endcase
            ph++;
        end
    end

    // Monitor: stability during stalls, first-word latency, scoreboard pop.
    initial begin
        logic          prev_stall, prev_valid;
        logic [31:0]   p_data;
        logic [3:0]    p_keep;
        logic          p_last;
        logic [UW-1:0] p_user;
        exp_t          e;
        prev_stall = 1'b0;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
                prev_valid = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("stall_valid", 128'(m_tvalid), 128'(1));
                    chk("stall_data", 128'(m_tdata), 128'(p_data));
                    chk("stall_keep", 128'(m_tkeep), 128'(p_keep));
                    chk("stall_last", 128'(m_tlast), 128'(p_last));
                    chk("stall_user", m_tuser, p_user);
                end
                if (m_tvalid && !prev_valid && q.size() != 0 && q[0].first)
                    chk("first_word_latency", 128'(cyc), 128'(hs_cyc + 1));
                if (m_tvalid) begin
                    if (q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_word: got data %0h, expected no word", m_tdata);
                    end else if (m_tready) begin
                        e = q.pop_front();
                        chk("word_data", 128'(m_tdata), 128'(e.data));
                        chk("word_keep", 128'(m_tkeep), 128'(e.keep));
                        chk("word_last", 128'(m_tlast), 128'(e.last));
                        chk("word_user", m_tuser, e.user);
                        words_seen++;
                        if (e.last) tl_cyc = cyc;
                    end
                end
                prev_stall = m_tvalid && !m_tready;
                prev_valid = m_tvalid;
                p_data = m_tdata;
                p_keep = m_tkeep;
                p_last = m_tlast;
                p_user = m_tuser;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int            base;
        int            t;
        int            len;
        logic [KW-1:0] k;

        rst_n    = 1'b0;
        s_tdata  = '0;
        s_tkeep  = '0;
        s_tuser  = '0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_s_tready", 128'(s_tready), 128'(1));
        chk("rst_m_tvalid", 128'(m_tvalid), 128'(0));
        chk("rst_m_tlast", 128'(m_tlast), 128'(0));
        chk("rst_m_tdata", 128'(m_tdata), 128'(0));
        chk("rst_m_tkeep", 128'(m_tkeep), 128'(0));
        chk("rst_m_tuser", m_tuser, 128'(0));
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // SHA256 with ready held high: 8 words on consecutive cycles.
        rdy_mode = 0;
        send_beat(rand_data(), ones(SHA256_BYTES), rand_user(SHA256));
        drain();
        chk("sha256_span", 128'(tl_cyc - hs_cyc), 128'(8));

        send_beat(rand_data(), ones(SHA224_BYTES), rand_user(SHA224));
        drain();
        chk("sha224_span", 128'(tl_cyc - hs_cyc), 128'(7));

        base = words_seen;
        send_beat(rand_data(), ones(SHA384_BYTES), rand_user(SHA384));
        drain();
        chk("sha384_words", 128'(words_seen - base), 128'(12));

        // SHA512 with ready toggling 1,0,0,1.
        rdy_mode = 1;
        base = words_seen;
        send_beat(rand_data(), ones(SHA512_BYTES), rand_user(SHA512));
        drain();
        chk("sha512_words", 128'(words_seen - base), 128'(16));

        // Back-to-back SHA256 beats.
        rdy_mode = 0;
        base = words_seen;
        send_beat(rand_data(), ones(SHA256_BYTES), rand_user(SHA256));
        send_beat(rand_data(), ones(SHA256_BYTES), rand_user(SHA256));
        chk("b2b_accept_gap", 128'(hs_cyc), 128'(tl_cyc + 1));
        drain();
        chk("b2b_words", 128'(words_seen - base), 128'(16));

        // Reset after word 3 of a SHA512 digest.
        base = words_seen;
        send_beat(rand_data(), ones(SHA512_BYTES), rand_user(SHA512));
        t = 0;
        while (words_seen < base + 4 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) chk("mid_reset_wait", 128'(words_seen - base), 128'(4));
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_m_tvalid", 128'(m_tvalid), 128'(0));
        chk("midrst_s_tready", 128'(s_tready), 128'(1));
        chk("midrst_m_tdata", 128'(m_tdata), 128'(0));
        chk("midrst_m_tuser", m_tuser, 128'(0));
        q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("postrst_s_tready", 128'(s_tready), 128'(1));
        chk("postrst_m_tvalid", 128'(m_tvalid), 128'(0));
        base = words_seen;
        send_beat(rand_data(), ones(SHA224_BYTES), rand_user(SHA224));
        drain();
        chk("postrst_sha224_words", 128'(words_seen - base), 128'(7));

        // Empty beat is swallowed; 26-byte beat ends with keep 0011.
        base = words_seen;
        send_beat(rand_data(), '0, rand_user(SHA256));
        @(negedge clk);
        chk("empty_s_tready", 128'(s_tready), 128'(1));
        repeat (5) @(posedge clk);
        #1;
        chk("empty_words", 128'(words_seen - base), 128'(0));
        send_beat(rand_data(), ones(26), rand_user(SHA224));
        drain();
        chk("len26_words", 128'(words_seen - base), 128'(7));

        // Random lengths, random lane masks below the top lane, random ready.
        rdy_mode = 2;
        for (int n = 0; n < 40; n++) begin
            len = $urandom_range(0, 64);
            k = '0;
            if (len > 0) begin
                for (int i = 0; i < len - 1; i++) k[i] = $urandom_range(0, 1);
                k[len-1] = 1'b1;
            end
            send_beat(rand_data(), k, rand_user(2'($urandom_range(0, 3))));
        end
        drain();
        chk("final_queue_empty", 128'(q.size()), 128'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/digest_serializer.md
DIGEST_SERIALIZER -- requirements
Module: digest_serializer

Interface
REQ-001 Parameter C_S_AXIS_DATA_WIDTH, default 512, slave digest beat width in bits.
REQ-002 Parameter C_M_AXIS_DATA_WIDTH, default 32, master word width in bits; fixed at 32.
REQ-003 Parameters C_S_AXIS_TUSER_WIDTH and C_M_AXIS_TUSER_WIDTH, default 128, sideband width in bits; the two SHALL be equal.
REQ-004 axis_aclk  in  1  single clock; all logic on the rising edge.
REQ-005 axis_resetn  in  1  reset, asynchronous and active-low.
REQ-006 s_axis_tdata  in  512  digest beat; byte lane 0 is bits [7:0].
REQ-007 s_axis_tkeep  in  64  valid byte lanes of the digest.
REQ-008 s_axis_tuser  in  128  sideband; sha_type is in bits [33:32].
REQ-009 s_axis_tvalid / s_axis_tlast  in  1 each  beat valid / last marker.
REQ-010 s_axis_tready  out  1  registered accept.
REQ-011 m_axis_tdata  out  32  output word.
REQ-012 m_axis_tkeep  out  4  valid bytes of the output word.
REQ-013 m_axis_tuser  out  128  captured sideband.
REQ-014 m_axis_tvalid / m_axis_tlast  out  1 each  word valid / last word of the digest.
REQ-015 m_axis_tready  in  1  downstream accept.

Function
REQ-016 The FSM SHALL have two states: IDLE (s_axis_tready=1) and SEND (s_axis_tready=0).
REQ-017 In IDLE, a slave handshake SHALL capture tdata, tuser and the byte length, and SHALL transition to SEND; s_axis_tlast is ignored because every beat is one complete digest.
REQ-018 Byte length L SHALL be the index of the highest set tkeep bit plus 1 (0 when tkeep is 0); word count W = ceil(L/4), giving 7/8/12/16 for SHA224/256/384/512.
REQ-019 The first output word SHALL be valid in the cycle after the slave handshake (latency 1), carrying bytes 0..3; word k carries bytes 4k..4k+3.
REQ-020 m_axis_tuser SHALL equal the captured tuser on every word of the digest.
REQ-021 m_axis_tkeep SHALL be 4'b1111 on every word except the last, which has the low (L mod 4) bits set, or 4'b1111 when L mod 4 is 0.
REQ-022 m_axis_tlast SHALL be 1 only on word W-1.
REQ-023 When m_axis_tvalid=1 and m_axis_tready=0, tdata, tkeep, tuser and tlast SHALL be held stable.
REQ-024 The word counter (5 bits) SHALL advance only on a master handshake.
REQ-025 A master handshake on the last word SHALL clear m_axis_tvalid and return the FSM to IDLE; s_axis_tready SHALL be 1 in the next cycle, leaving one bubble between digests.
REQ-026 A beat with tkeep=0 SHALL be accepted and discarded: no output word, and the FSM stays in IDLE with tready held at 1.
REQ-027 The block SHALL ignore s_axis_tvalid while in SEND; upstream holds the beat under AXIS rules.

Reset
REQ-028 Asserting axis_resetn low SHALL immediately force: IDLE, s_axis_tready=1, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, m_axis_tkeep=0, m_axis_tuser=0, counter=0.
REQ-029 Reset asserted mid-digest SHALL abort the digest; after release, no residual word of that digest SHALL be emitted.
REQ-030 Release of axis_resetn SHALL be synchronised to axis_aclk before the FSM leaves reset.

Structure
REQ-031 The shared package digest_pkg SHALL hold: the SHA224/256/384/512 codes (2'b00..2'b11), the tuser sha_type offset (32), the per-type byte counts (28/32/48/64) and the FSM state type.
REQ-032 The tkeep-to-length priority encoder SHALL be a sub-module named keep_to_len (64-bit in, 7-bit L out).
REQ-033 The target size is 120-400 lines of RTL; the design SHALL contain no memories, the 512-bit holding register being the only wide storage.

Verification
REQ-034 SHA256 beat, tkeep = 32 ones, m_axis_tready=1 -> 8 words on consecutive cycles; word 0 = tdata[31:0], word 7 = tdata[255:224] with tlast=1; all tkeep = 4'hF.
REQ-035 SHA224 beat, tkeep = 28 ones -> 7 words, tlast on word 6; SHA384 beat, tkeep = 48 ones -> 12 words.
REQ-036 SHA512 beat with m_axis_tready toggling 1,0,0,1,... -> 16 words, outputs stable in every stall cycle, tuser unchanged on all 16 words.
REQ-037 Two back-to-back SHA256 beats -> second beat accepted 1 cycle after the last word of the first; 16 words total, in order.
REQ-038 Reset asserted after word 3 of a SHA512 digest -> m_axis_tvalid=0 at once and s_axis_tready=1 after release; a new SHA224 beat yields exactly 7 words.
REQ-039 Beat with tkeep=0 -> accepted, no m_axis_tvalid; tkeep=26 ones -> 7 words, last word tkeep=4'b0011.
